// File: rtl/sobol_pkg.sv
// Shared constants and types for the Sobol sequencer and the external Sobol generator.
package sobol_pkg;

  localparam int SOBOL_M = 50;
  localparam int DIM_W   = $clog2(SOBOL_M);

  typedef logic [31:0]      index_t;
  typedef logic [DIM_W-1:0] dim_t;

endpackage

// File: rtl/sobol_sequencer_if.sv
// Request, generator and output-stream signals of the Sobol sequencer.
interface sobol_sequencer_if
  import sobol_pkg::*;
#(
  parameter int DW = DIM_W
);

  logic          start;
  index_t        start_index;
  index_t        num_points;
  logic [DW:0]   num_dims;

  index_t        sobol_N;
  logic [DW-1:0] sobol_dim;
  logic [31:0]   sobol_in;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  index_t        out_index;
  logic [DW-1:0] out_dim;
  logic          out_last_dim;
  logic          out_last;

  logic          busy;
  logic          done;

  modport master (
    output start, start_index, num_points, num_dims, sobol_in, out_ready,
    input  sobol_N, sobol_dim, out_valid, out_data, out_index, out_dim,
           out_last_dim, out_last, busy, done
  );

  modport slave (
    input  start, start_index, num_points, num_dims, sobol_in, out_ready,
    output sobol_N, sobol_dim, out_valid, out_data, out_index, out_dim,
           out_last_dim, out_last, busy, done
  );

endinterface

// File: rtl/sobol_seq_counter.sv
// Point-major fetch pointer: index outer, dimension inner, with end-of-point and end-of-run flags.
module sobol_seq_counter
  import sobol_pkg::*;
#(
  parameter int DW = DIM_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          advance,
  input  index_t        start_index,
  input  index_t        num_points,
  input  logic [DW:0]   num_dims,
  output index_t        idx,
  output logic [DW-1:0] dim,
  output logic          pending,
  output logic          last_dim,
  output logic          last
);

  index_t        pts_left;
  logic [DW-1:0] dim_max;

  // Termination uses the remaining-points count, never points*dims.
  assign last_dim = (dim == dim_max);
  assign last     = last_dim && (pts_left == 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      dim      <= '0;
      pts_left <= '0;
      dim_max  <= '0;
      pending  <= 1'b0;
    end else if (clear) begin
      idx      <= '0;
      dim      <= '0;
      pts_left <= '0;
      dim_max  <= '0;
      pending  <= 1'b0;
    end else if (load) begin
      idx      <= start_index;
      dim      <= '0;
      pts_left <= num_points;
      dim_max  <= DW'(num_dims - 1'b1);
      pending  <= (num_points != '0) && (num_dims != '0);
    end else if (advance && pending) begin
      if (last_dim) begin
        dim      <= '0;
        idx      <= idx + 32'd1;  // wraps modulo 2^32
        pts_left <= pts_left - 32'd1;
        if (pts_left == 32'd1) pending <= 1'b0;
      end else begin
        dim <= dim + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobol_sequencer.sv
// Walks (index, dimension) pairs through an external combinational Sobol generator and streams the results.
module sobol_sequencer
  import sobol_pkg::*;
#(
  parameter int M  = SOBOL_M,
  parameter int DW = $clog2(M)
) (
  input logic             clk,
  input logic             rst,
  sobol_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [DW:0]   dims_clamped;
  logic          start_ok, run_ok, load_out, final_xfer;
  logic          pending, cnt_last_dim, cnt_last;
  index_t        cnt_idx;
  logic [DW-1:0] cnt_dim;

  logic          ov, o_last_dim, o_last;
  logic [31:0]   o_data;
  index_t        o_index;
  logic [DW-1:0] o_dim;

  assign dims_clamped = (bus.num_dims > (DW+1)'(M)) ? (DW+1)'(M) : bus.num_dims;
  assign start_ok     = (state == S_IDLE) && bus.start;
  assign run_ok       = (bus.num_points != '0) && (dims_clamped != '0);
  // A slot is free when the output register is empty or being drained this cycle.
  assign load_out     = (state == S_RUN) && pending && (!ov || bus.out_ready);
  assign final_xfer   = (state == S_RUN) && ov && bus.out_ready && o_last;

  sobol_seq_counter #(.DW(DW)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (final_xfer),
    .load        (start_ok && run_ok),
    .advance     (load_out),
    .start_index (bus.start_index),
    .num_points  (bus.num_points),
    .num_dims    (dims_clamped),
    .idx         (cnt_idx),
    .dim         (cnt_dim),
    .pending     (pending),
    .last_dim    (cnt_last_dim),
    .last        (cnt_last)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state <= run_ok ? S_RUN : S_DONE;
        S_RUN:   if (final_xfer) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov         <= 1'b0;
      o_data     <= '0;
      o_index    <= '0;
      o_dim      <= '0;
      o_last_dim <= 1'b0;
      o_last     <= 1'b0;
    end else if (load_out) begin
      ov         <= 1'b1;
      o_data     <= bus.sobol_in;
      o_index    <= cnt_idx;
      o_dim      <= cnt_dim;
      o_last_dim <= cnt_last_dim;
      o_last     <= cnt_last;
    end else if (bus.out_ready) begin
      ov <= 1'b0;
    end
  end

  assign bus.sobol_N      = cnt_idx;
  assign bus.sobol_dim    = cnt_dim;
  assign bus.out_valid    = ov;
  assign bus.out_data     = o_data;
  assign bus.out_index    = o_index;
  assign bus.out_dim      = o_dim;
  assign bus.out_last_dim = o_last_dim;
  assign bus.out_last     = o_last;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_DONE);

endmodule

// File: tb/tb_sobol_sequencer.sv
// Directed bench for sobol_sequencer with a stand-in combinational generator model.
module tb_sobol_sequencer;
  import sobol_pkg::*;

  typedef struct {
    logic [31:0]    start_index;
    logic [31:0]    num_points;
    logic [DIM_W:0] num_dims;
    bit             rand_ready;
    bit             restart;
    int             exp_count;
    int             eff_dims;
  } vec_t;

  typedef struct {
    logic [72:0] bits;
    int          cyc;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  xfer_t       q[$];
  int          done_cnt;
  int          done_cyc;
  int          first_valid_cyc;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [72:0] held;
  vec_t        vecs[8];

  sobol_sequencer_if #(.DW(DIM_W)) bus ();

  sobol_sequencer #(.M(SOBOL_M), .DW(DIM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sobol_ref(input logic [31:0] n, input logic [DIM_W-1:0] d);
    return (n * 32'h9E3779B1) ^ (32'(d) * 32'h85EBCA6B) ^ (n >> 7) ^ {d, 26'h0};
  endfunction

  assign bus.sobol_in = sobol_ref(bus.sobol_N, bus.sobol_dim);

  function automatic logic [72:0] pack_out();
    return {bus.out_valid, bus.out_index, bus.out_dim, bus.out_last_dim, bus.out_last, bus.out_data};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 128'(pack_out()), 128'(held));
      if (bus.out_valid && bus.out_ready) q.push_back('{bits: pack_out(), cyc: cyc});
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held       = pack_out();
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_data"}, 128'(bus.out_data), 128'(0));
    check({tag, "_index"}, 128'(bus.out_index), 128'(0));
    check({tag, "_dim"}, 128'(bus.out_dim), 128'(0));
    check({tag, "_lastdim"}, 128'(bus.out_last_dim), 128'(0));
    check({tag, "_last"}, 128'(bus.out_last), 128'(0));
    check({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_done"}, 128'(bus.done), 128'(0));
    check({tag, "_sobolN"}, 128'(bus.sobol_N), 128'(0));
    check({tag, "_soboldim"}, 128'(bus.sobol_dim), 128'(0));
  endtask

  task automatic issue_start(input logic [31:0] si, input logic [31:0] np, input logic [DIM_W:0] nd);
    @(negedge clk);
    bus.start_index = si;
    bus.num_points  = np;
    bus.num_dims    = nd;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int          accept_cyc;
    int          k;
    logic [31:0] idx;
    logic [72:0] exp_bits;
    string       tag;
    tag             = $sformatf("v%0d", vi);
    q.delete();
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    rand_ready      = v.rand_ready;
    @(negedge clk);
    bus.start_index = v.start_index;
    bus.num_points  = v.num_points;
    bus.num_dims    = v.num_dims;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    check({tag, "_busy"}, 128'(bus.busy), 128'(1));
    @(negedge clk);
    bus.start = 1'b0;
    if (v.restart) begin
      @(negedge clk);
      bus.start_index = v.start_index + 32'd1000;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      @(negedge clk);
      #2;
    end
    repeat (3) @(negedge clk);
    #2;
    rand_ready = 1'b0;
    check({tag, "_done_seen"}, 128'(done_cnt), 128'(1));
    check({tag, "_count"}, 128'(q.size()), 128'(v.exp_count));
    k = 0;
    for (int p = 0; p < int'(v.num_points) && k < v.exp_count; p++) begin
      idx = v.start_index + 32'(p);
      for (int d = 0; d < v.eff_dims; d++) begin
        exp_bits = {1'b1, idx, DIM_W'(d), d == v.eff_dims - 1,
                    (d == v.eff_dims - 1) && (p == int'(v.num_points) - 1),
                    sobol_ref(idx, DIM_W'(d))};
        if (k < q.size()) check($sformatf("%s_elem%0d", tag, k), 128'(q[k].bits), 128'(exp_bits));
        k++;
      end
    end
    if (v.exp_count > 0 && q.size() > 0) begin
      check({tag, "_latency"}, 128'(first_valid_cyc - accept_cyc), 128'(1));
      check({tag, "_done_cyc"}, 128'(done_cyc - q[q.size()-1].cyc), 128'(1));
      if (!v.rand_ready)
        check({tag, "_throughput"}, 128'(q[q.size()-1].cyc - q[0].cyc), 128'(v.exp_count - 1));
    end else begin
      check({tag, "_no_valid"}, 128'(first_valid_cyc), 128'(-1));
      check({tag, "_done_cyc"}, 128'(done_cyc - accept_cyc), 128'(0));
    end
    check({tag, "_idle_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_idle_sobolN"}, 128'(bus.sobol_N), 128'(0));
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.start_index = '0;
    bus.num_points  = '0;
    bus.num_dims    = '0;
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;

    //        start_index   points  dims  rand  restart count eff
    vecs[0] = '{32'd10,       32'd1,  7'd50, 1'b0, 1'b0, 50,  50};
    vecs[1] = '{32'd0,        32'd10, 7'd1,  1'b0, 1'b0, 10,  1};
    vecs[2] = '{32'd0,        32'd4,  7'd3,  1'b1, 1'b0, 12,  3};
    vecs[3] = '{32'hFFFFFFFE, 32'd3,  7'd2,  1'b0, 1'b0, 6,   2};
    vecs[4] = '{32'd5,        32'd0,  7'd4,  1'b0, 1'b0, 0,   4};
    vecs[5] = '{32'd5,        32'd3,  7'd0,  1'b0, 1'b0, 0,   0};
    vecs[6] = '{32'd100,      32'd2,  7'd60, 1'b0, 1'b0, 100, 50};
    vecs[7] = '{32'd0,        32'd10, 7'd3,  1'b0, 1'b1, 30,  3};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort a 20-element run after its fifth transfer.
    q.delete();
    done_cnt = 0;
    issue_start(32'd77, 32'd4, 7'd5);
    for (int i = 0; i < 200 && q.size() < 5; i++) begin
      @(negedge clk);
      #2;
    end
    check("abort_reached5", 128'(q.size()), 128'(5));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("abort_no_more_xfers", 128'(q.size()), 128'(5));
    check("abort_no_done", 128'(done_cnt), 128'(0));

    run_vec(8, '{32'd500, 32'd2, 7'd2, 1'b0, 1'b0, 4, 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
